seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned restoring divider for the datapath's integer divide path.
- It is the subtract-side counterpart of the existing wide unsigned adder blocks.
- It computes one quotient bit per cycle with a trial subtract-and-shift, behind a start/busy/done handshake.
- It feeds the execute stage. The issuing logic holds operands externally only for the start cycle.

---
 rtl/div_pkg.sv | 22 ++
 rtl/seq_restoring_divider_trial_sub.sv | 24 ++
 rtl/seq_restoring_divider.sv | 141 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and constants for the sequential restoring divider
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Replicated across WIDTH to form the divide-by-zero quotient
  localparam logic DZ_QUOTIENT_FILL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider_trial_sub.sv
// ============================================================================
// unsignedTrialSubtractor : (W+1)-bit trial subtract for one restoring step
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module unsignedTrialSubtractor #(
  parameter int W = 32
) (
  input  logic [W:0]   minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] diff,
  output logic         neg
);

  logic [W:0] full_diff;

  assign full_diff = minuend - {1'b0, subtrahend};
  assign diff      = full_diff[W-1:0];
  assign neg       = full_diff[W];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// seq_restoring_divider : multi-cycle unsigned restoring divider, 1 bit/cycle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial_min;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_neg;

  // The guard bit of the partial remainder only exists inside the trial
  // difference: a kept remainder is always < D, so its top bit is never set.
  assign trial_min = {r_q, q_q[WIDTH-1]};

  unsignedTrialSubtractor #(
    .W (WIDTH)
  ) u_trial_sub (
    .minuend    (trial_min),
    .subtrahend (d_q),
    .diff       (trial_diff),
    .neg        (trial_neg)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = (divisor == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        if (!trial_neg) begin
          r_d = trial_diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial_min[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (d_q == '0) begin
          // Q was never shifted on this path, so it still holds the dividend
          quo_d = {WIDTH{DZ_QUOTIENT_FILL}};
          rem_d = q_q;
          dz_d  = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = r_q;
          dz_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// tb_seq_restoring_divider : randomized self-checking bench for the divider
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;
  localparam int LIMIT = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present operands for one edge, then scramble them (don't-care after accept).
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Advance until done is seen; cyc counts edges after the accept edge.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc;
    start_op(32'd100, 32'd7);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc !== LAT) begin
      errors++; $display("FAIL basic_latency: got %0d required %0d", cyc, LAT);
    end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b busy=%b required q=14 r=2 dz=0 busy=0",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || quotient !== 32'd14) begin
      errors++; $display("FAIL basic_done_pulse: done=%b q=%0d required done=0 q=14", done, quotient);
    end
  endtask

  task automatic test_max_operands;
    int cyc;
    start_op('1, 32'd1);
    wait_done(0, cyc);
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== '0) begin
      errors++; $display("FAIL max_div1: q=%h r=%h required q=ffffffff r=0", quotient, remainder);
    end
    @(posedge clk); #1;
    start_op('1, '1);
    wait_done(0, cyc);
    checks++;
    if (quotient !== 32'd1 || remainder !== '0 || cyc !== LAT) begin
      errors++;
      $display("FAIL max_self: q=%h r=%h lat=%0d required q=1 r=0 lat=%0d", quotient, remainder, cyc, LAT);
    end
  endtask

  task automatic test_div_by_zero;
    int cyc;
    @(posedge clk); #1;
    start_op(32'd5, 32'd0);
    wait_done(0, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++; $display("FAIL dz_latency: got %0d required 1", cyc);
    end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: q=%h r=%0d dz=%b required q=ffffffff r=5 dz=1", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    start_op(32'd9, 32'd3);
    wait_done(0, cyc);
    checks++;
    if (quotient !== 32'd3 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear: q=%0d r=%0d dz=%b required q=3 r=0 dz=0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    @(posedge clk); #1;
    start_op(32'd3, 32'd10);
    cyc = 0;
    repeat (9) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (quotient !== 32'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_mid_op: q=%0d busy=%b required q=3 busy=1", quotient, busy);
    end
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    wait_done(cyc, cyc);
    checks++;
    if (cyc !== LAT || quotient !== '0 || remainder !== 32'd3) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d q=%0d r=%0d required lat=%0d q=0 r=3", cyc, quotient, remainder, LAT);
    end
  endtask

  task automatic test_reset_mid_op;
    int cyc;
    bit seen;
    @(posedge clk); #1;
    start_op(32'd1000, 32'd9);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b dz=%b q=%h r=%h required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: done pulse seen=%b required 0", seen);
    end
    start_op(32'd1000, 32'd9);
    wait_done(0, cyc);
    checks++;
    if (quotient !== 32'd111 || remainder !== 32'd1 || cyc !== LAT) begin
      errors++;
      $display("FAIL reset_restart: q=%0d r=%0d lat=%0d required q=111 r=1 lat=%0d", quotient, remainder, cyc, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(posedge clk); #1;
    start_op(32'd20, 32'd4);
    wait_done(0, cyc);
    checks++;
    if (quotient !== 32'd5 || remainder !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first: q=%0d r=%0d busy=%b required q=5 r=0 busy=0", quotient, remainder, busy);
    end
    start_op(32'd77, 32'd8);
    checks++;
    if (busy !== 1'b1 || quotient !== 32'd5) begin
      errors++; $display("FAIL b2b_accept: busy=%b q=%0d required busy=1 q=5", busy, quotient);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc !== LAT || quotient !== 32'd9 || remainder !== 32'd5) begin
      errors++;
      $display("FAIL b2b_second: gap=%0d q=%0d r=%0d required gap=%0d q=9 r=5", cyc, quotient, remainder, LAT);
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [WIDTH-1:0] a, b, eq, er;
    logic             edz;
    logic [2*WIDTH-1:0] recon;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 255));
        1: b = '0;
        2: begin b = $urandom; a = a >> $urandom_range(0, 31); end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == '0) begin
        eq = '1; er = a; edz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0;
      end
      start_op(a, b);
      wait_done(0, cyc);
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || cyc !== ((b == '0) ? 1 : LAT)) begin
        errors++;
        $display("FAIL random_%0d: %h/%h got q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=%b",
                 i, a, b, quotient, remainder, div_by_zero, cyc, eq, er, edz);
      end
      if (b != '0) begin
        recon = 64'(quotient) * 64'(b) + 64'(remainder);
        checks++;
        if (recon !== 64'(a) || !(remainder < b)) begin
          errors++;
          $display("FAIL invariant_%0d: q*d+r=%h required %h, r=%h d=%h", i, recon, 64'(a), remainder, b);
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max_operands;
    test_div_by_zero;
    test_ignore_start;
    test_reset_mid_op;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
